// File: rtl/gcd_scheduler.sv
// Round-robin arbiter sharing one subtractive GCD engine between N requesters.
// Optional abort-after-MAX_ITER-subtractions feature: define GCD_SCHED_TIMEOUT_EN.
module gcd_scheduler #(
   parameter int N        = 4,
   parameter int W        = 5,
   parameter int MAX_ITER = 40,
   localparam int IDW     = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic [N*W-1:0]   a_in,
   input  logic [N*W-1:0]   b_in,
   output logic [N-1:0]     gnt,
   output logic             busy,
   output logic             rsp_valid,
   output logic [IDW-1:0]   rsp_id,
   output logic [W-1:0]     rsp_result,
   output logic             rsp_err
);

   typedef enum logic {IDLE, CALC} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [W-1:0]     rsp_result_q, rsp_result_d;
   logic             win_found;
   logic [IDW-1:0]   win_idx;
   logic [IDW-1:0]   cand;

`ifdef GCD_SCHED_TIMEOUT_EN
   localparam int ITW = $clog2(MAX_ITER + 1);
   logic [ITW-1:0]   iter_q, iter_d;
   logic             rsp_err_q, rsp_err_d;
`endif

   // Search upward from last+1 with wrap; i == N lands back on last itself.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_q;
      cand      = '0;
      for (int i = 1; i <= N; i++) begin
         cand = last_q + IDW'(i);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      a_d          = a_q;
      b_d          = b_q;
      gnt_d        = '0;
      rsp_valid_d  = 1'b0;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
`ifdef GCD_SCHED_TIMEOUT_EN
      iter_d       = iter_q;
      rsp_err_d    = rsp_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_found) begin
               a_d              = a_in[win_idx*W +: W];
               b_d              = b_in[win_idx*W +: W];
               last_d           = win_idx;
               gnt_d            = '0;
               gnt_d[win_idx]   = 1'b1;
               state_d          = CALC;
`ifdef GCD_SCHED_TIMEOUT_EN
               iter_d           = '0;
`endif
            end
         end
         CALC: begin
            if (a_q == '0 || b_q == '0) begin
               rsp_result_d = (a_q >= b_q) ? a_q : b_q;
               rsp_id_d     = last_q;
               rsp_valid_d  = 1'b1;
               state_d      = IDLE;
`ifdef GCD_SCHED_TIMEOUT_EN
               rsp_err_d    = 1'b0;
            end else if (iter_q == ITW'(MAX_ITER)) begin
               rsp_result_d = '0;
               rsp_id_d     = last_q;
               rsp_err_d    = 1'b1;
               rsp_valid_d  = 1'b1;
               state_d      = IDLE;
`endif
            end else begin
               if (a_q >= b_q) a_d = a_q - b_q;
               else            b_d = b_q - a_q;
`ifdef GCD_SCHED_TIMEOUT_EN
               iter_d = iter_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_q       <= IDW'(N - 1);
         a_q          <= '0;
         b_q          <= '0;
         gnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
`ifdef GCD_SCHED_TIMEOUT_EN
         iter_q       <= '0;
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         a_q          <= a_d;
         b_q          <= b_d;
         gnt_q        <= gnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
`ifdef GCD_SCHED_TIMEOUT_EN
         iter_q       <= iter_d;
         rsp_err_q    <= rsp_err_d;
`endif
      end
   end

   assign gnt        = gnt_q;
   assign busy       = (state_q == CALC);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;

`ifdef GCD_SCHED_TIMEOUT_EN
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
   // MAX_ITER has no effect in this build; the block only references it.
   if (MAX_ITER < 0) begin : g_max_iter_unused
   end
`endif

endmodule

// File: tb/tb_gcd_scheduler.sv
// Bench for gcd_scheduler: directed scenarios plus randomized batches, checked by a
// response scoreboard fed from a Euclid-based reference model.
module tb_gcd_scheduler;
  localparam int N = 4;
  localparam int W = 5;
  localparam int IDW = $clog2(N);
`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int MAX_ITER = 8;
`else
  localparam int MAX_ITER = 40;
`endif

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   result;
    logic           err;
    logic [15:0]    lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_gnt_cyc = 0;
  int         model_last = N - 1;
  logic [W-1:0] op_a[N];
  logic [W-1:0] op_b[N];

  gcd_scheduler #(.N(N), .W(W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Subtraction count of the subtractive algorithm equals the sum of Euclid quotients.
  function automatic exp_t make_exp(input int id, input int a, input int b);
    exp_t e;
    int x, y, k;
    x = a; y = b; k = 0;
    while (x != 0 && y != 0) begin
      if (x >= y) begin k += x / y; x = x % y; end
      else begin k += y / x; y = y % x; end
    end
    e.id = IDW'(id);
    e.result = W'(x + y);
    e.err = 1'b0;
    e.lat = 16'(k + 1);
`ifdef GCD_SCHED_TIMEOUT_EN
    if (k > MAX_ITER) begin
      e.result = '0;
      e.err = 1'b1;
      e.lat = 16'(MAX_ITER + 1);
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- requester agents: drop req on seeing gnt ----------------
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (gnt[i] === 1'b1) req[i] = 1'b0;
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (gnt !== '0) last_gnt_cyc = cyc;
    if (rsp_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d result=%0d err=%0d expected no response",
                 rsp_id, rsp_result, rsp_err);
      end else begin
        e = exp_q.pop_front();
        if (rsp_id !== e.id || rsp_result !== e.result || rsp_err !== e.err ||
            (cyc - last_gnt_cyc) != int'(e.lat)) begin
          errors++;
          $display("FAIL rsp: got id=%0d result=%0d err=%0d lat=%0d expected id=%0d result=%0d err=%0d lat=%0d",
                   rsp_id, rsp_result, rsp_err, cyc - last_gnt_cyc, e.id, e.result, e.err, e.lat);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_gnt(input logic [N-1:0] exp_oh);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt === '0 && n < 300);
    check("gnt", 32'(gnt), 32'(exp_oh));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Raise all requesters in mask together; they are served in round-robin order from model_last.
  task automatic run_batch(input logic [N-1:0] mask);
    int order[$];
    logic [N-1:0] oh;
    for (int i = 0; i < N; i++)
      if (mask[i]) begin
        a_in[i*W +: W] = op_a[i];
        b_in[i*W +: W] = op_b[i];
      end
    for (int j = 1; j <= N; j++) begin
      int idx;
      idx = (model_last + j) % N;
      if (mask[idx]) begin
        order.push_back(idx);
        exp_q.push_back(make_exp(idx, int'(op_a[idx]), int'(op_b[idx])));
      end
    end
    req = req | mask;
    foreach (order[k]) begin
      oh = '0;
      oh[order[k]] = 1'b1;
      wait_gnt(oh);
      model_last = order[k];
    end
    drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    logic [N-1:0] mask;
    reset = 1'b1;
    req = '0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_gnt", 32'(gnt), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_id", 32'(rsp_id), 0);
    check("reset_rsp_result", 32'(rsp_result), 0);
    check("reset_rsp_err", 32'(rsp_err), 0);

    // Single request (30,10) from requester 0
    op_a[0] = 5'd30; op_b[0] = 5'd10;
    a_in[0 +: W] = op_a[0]; b_in[0 +: W] = op_b[0];
    exp_q.push_back(make_exp(0, 30, 10));
    req[0] = 1'b1;
    wait_gnt(4'b0001);
    model_last = 0;
    check("busy_at_gnt", 32'(busy), 1);
    @(negedge clk);
    check("gnt_pulse", 32'(gnt), 0);
    drain();
    repeat (3) @(negedge clk);
    check("result_hold", 32'(rsp_result), 10);
    check("idle_valid_low", 32'(rsp_valid), 0);
    check("idle_busy_low", 32'(busy), 0);

    // Round robin across all four requesters
    op_a[0] = 5'd15; op_b[0] = 5'd25;
    op_a[1] = 5'd15; op_b[1] = 5'd6;
    op_a[2] = 5'd0;  op_b[2] = 5'd4;
    op_a[3] = 5'd0;  op_b[3] = 5'd0;
    run_batch(4'b1111);
    op_a[0] = 5'd12; op_b[0] = 5'd18;
    op_a[3] = 5'd7;  op_b[3] = 5'd21;
    run_batch(4'b1001);

    // Zero operand and longest pair
    op_a[1] = 5'd0;  op_b[1] = 5'd4;
    run_batch(4'b0010);
    op_a[2] = 5'd31; op_b[2] = 5'd1;
    run_batch(4'b0100);
    op_a[1] = 5'd9;  op_b[1] = 5'd0;
    run_batch(4'b0010);

    // Reset during CALC: discarded, priority restarts at requester 0
    a_in[0 +: W] = 5'd31; b_in[0 +: W] = 5'd1;
    req[0] = 1'b1;
    wait_gnt(4'b0001);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_gnt", 32'(gnt), 0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    check("rst_mid_rsp_result", 32'(rsp_result), 0);
    check("rst_mid_rsp_id", 32'(rsp_id), 0);
    check("rst_mid_rsp_err", 32'(rsp_err), 0);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    model_last = N - 1;
    repeat (40) @(negedge clk);
    op_a[2] = 5'd20; op_b[2] = 5'd8;
    op_a[3] = 5'd27; op_b[3] = 5'd18;
    run_batch(4'b1100);

    // Withdraw: req[1] raised and dropped while requester 0 is computing
    op_a[0] = 5'd31; op_b[0] = 5'd1;
    fork
      run_batch(4'b0001);
      begin
        repeat (5) @(negedge clk);
        req[1] = 1'b1;
        repeat (10) @(negedge clk);
        req[1] = 1'b0;
      end
    join
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (gnt !== '0) seen++;
    end
    check("withdraw_no_gnt", 32'(seen), 0);

    // Randomized batches
    for (int t = 0; t < 15; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        op_a[i] = W'($urandom_range(0, (1 << W) - 1));
        op_b[i] = W'($urandom_range(0, (1 << W) - 1));
      end
      run_batch(mask);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Round-robin scheduler that shares one iterative subtractive GCD engine between `N` requesters. Each requester presents an operand pair and holds a request. The block grants one requester at a time, captures its operands, iterates the engine to completion, and returns the result tagged with the requester index. It sits between the operand sources (button/switch front ends, control logic) and the result consumers such as the seven-segment display path.

## Interface
- `N`, default 4: number of requesters; power of two, 2..8.
- `W`, default 5: operand/result width.
- `MAX_ITER`, default 40: subtraction limit before abort; used only with `GCD_SCHED_TIMEOUT_EN`.
- `IDW` (derived): `clog2(N)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N  per-requester request level; held until that requester's `gnt` bit is seen.
- `a_in`  in  N*W  operand A per requester; slice i is `[i*W +: W]`.
- `b_in`  in  N*W  operand B per requester; same packing as `a_in`.
- `gnt`  out  N  one-hot, one-cycle pulse; operands of that requester have been captured.
- `busy`  out  1  high while the engine holds an operand pair (CALC state).
- `rsp_valid`  out  1  one-cycle pulse; response fields valid.
- `rsp_id`  out  IDW  requester index of the response.
- `rsp_result`  out  W  GCD result; holds its value until the next response.
- `rsp_err`  out  1  abort flag, qualified by `rsp_valid`; tied 0 without the macro.

## Operation
- States: IDLE, CALC.
- IDLE, on a clock edge with `req != 0`:
  - Winner is the first set `req` bit searching upward, with wrap, from `last+1`.
  - Load `a`/`b` from the winner's slices.
  - `last <= winner`, `gnt <= onehot(winner)`, `iter <= 0`, go to CALC.
- IDLE with `req == 0`: stay in IDLE.
- CALC, evaluated per edge in priority order:
  1. `a == 0` or `b == 0`: `rsp_result <= max(a,b)`, `rsp_id <= last`, `rsp_err <= 0`, `rsp_valid <= 1`, go to IDLE.
  2. (macro only) `iter == MAX_ITER`: `rsp_result <= 0`, `rsp_err <= 1`, `rsp_valid <= 1`, go to IDLE.
  3. `a >= b`: `a <= a - b`. Otherwise `b <= b - a`. Then `iter <= iter + 1`.
- `req` is ignored in CALC.
  - A requester drops `req` on seeing `gnt`. A `req` still high when the block returns to IDLE counts as a new request.
  - A requester may withdraw `req` before its grant without side effects.
- Arithmetic: unsigned W bits. Subtraction never underflows because the smaller operand is always the one subtracted.
- `gcd(0,0)` = 0 with `rsp_err` = 0. `gcd(x,0)` = x.
- `iter` is `clog2(MAX_ITER+1)` bits wide and cannot wrap.

## Timing
- Reset values (asynchronous):
  - State IDLE, `last = N-1`, so requester 0 has first priority.
  - `gnt`, `busy`, `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_err`, `a`, `b`, `iter` all 0.
- Capture edge E0: `gnt` is high for the cycle after E0, and `busy` goes high at the same time.
- A pair needing k subtractions: subtractions occur on E1..Ek, and the termination edge E(k+1) sets `rsp_valid`. Latency from capture to `rsp_valid` is k+1 cycles.
- `busy` falls on the same edge that raises `rsp_valid`.
  - IDLE may capture a new pair on the next edge, so `gnt` for the next requester can coincide with the cycle after `rsp_valid`.
  - Peak throughput is one response per k+2 cycles.
- Reset asserted during CALC: the operation is discarded, no `rsp_valid` is produced, and all outputs return to reset values at once.

## Configuration
- `GCD_SCHED_TIMEOUT_EN` defined:
  - `iter` counter and CALC rule 2 are built.
  - A pair still unfinished after `MAX_ITER` subtractions is aborted with `rsp_err = 1` and `rsp_result = 0`.
- Not defined:
  - No counter; CALC always runs to completion.
  - `rsp_err` is constant 0 and `MAX_ITER` is unused.

## Test plan
- Single request: after reset, `req[0]` with (30,10).
  - `gnt = 0001` for 1 cycle.
  - `rsp_valid` 4 cycles after capture, `rsp_id = 0`, `rsp_result = 10`.
  - `rsp_result` holds afterwards.
- Round robin: all four `req` high after reset, each dropped on its `gnt`, operands (15,25), (15,6), (0,4), (0,0).
  - Grants in order 0,1,2,3.
  - Results 5, 3, 4, 0 with matching `rsp_id`.
  - Then re-raise `req[0]` and `req[3]` together with `last = 3` → `req[0]` is granted first.
- Zero operand: (0,4) → `rsp_valid` 1 cycle after capture, result 4. (31,1) → 32 cycles, result 1.
- Reset mid-operation: (31,1) granted, `reset` pulsed 5 cycles later.
  - No `rsp_valid`, all outputs 0.
  - Next request from requester 2 is granted ahead of requester 3.
- Withdraw: `req[1]` raised during requester 0's CALC, dropped before IDLE → no `gnt[1]`, no extra response.
- Timeout (macro defined, `MAX_ITER = 8`): (31,1) → `rsp_valid` 9 cycles after capture, `rsp_err = 1`, `rsp_result = 0`. (30,10) in the same build completes normally with `rsp_err = 0`.
